tx_num_sequencer: RTL
=====================

Name: tx_num_sequencer

Overview:
- Transmit-side word counter and frame-phase sequencer for the 10G MAC TX engine, 64-bit (8-byte) datapath.
- Latches the client frame length at frame start and sequences the frame phases: preamble/SFD word, data words, pad words, FCS slot, inter-frame gap.
- Issues per-word data requests to the client, end-of-phase strobes, and the valid-byte mask of the final data word.
- Sits between the TX client interface and the TX data-path/CRC/aligner logic.

Parameters:
- LEN_W, 13, width of frame length and word counters.
- MAX_LEN, 1518, largest accepted frame length in bytes (header + payload, no FCS).
- MIN_LEN, 60, minimum length before FCS; shorter frames are padded up to this.
- IFG_WORDS, 2, idle words forced after the FCS slot.

Ports:
- txclk  in  1  transmit clock.
- reset  in  1  asynchronous, active-low reset.
- start_tx  in  1  request to start a frame; sampled only in IDLE.
- frame_len  in  LEN_W  frame length in bytes; valid with start_tx.
- client_valid  in  1  client word available while data_req is high.
- start_ack  out  1  one-cycle pulse: frame accepted.
- len_err  out  1  one-cycle pulse: frame_len out of range, frame rejected.
- in_pre  out  1  preamble/SFD word cycle.
- data_req  out  1  DATA phase: client word consumed this cycle.
- in_pad  out  1  PAD phase: pad word cycle.
- in_fcs  out  1  FCS slot cycle.
- in_ifg  out  1  IFG cycle.
- word_cnt  out  LEN_W  index of the current data/pad word, 0-based.
- last_mask  out  8  valid-byte mask of the current word; low bytes first.
- end_data_cnt  out  1  high on the last DATA word.
- end_pad_cnt  out  1  high on the last PAD word.
- underrun  out  1  one-cycle pulse: client_valid was low during DATA.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, synchronous release): state IDLE, counters 0, all outputs 0.
- FSM states: IDLE, PRE, DATA, PAD, FCS, IFG.
- IDLE:
  - start_tx with 1 <= frame_len <= MAX_LEN: latch len, start_ack=1, next state PRE.
  - start_tx with frame_len out of range: len_err=1, stay in IDLE.
- PRE: one cycle, then DATA; word_cnt cleared to 0.
- Word counts:
  - dw = (len+7)>>3.
  - Pad-enabled: ew = (max(len,MIN_LEN)+7)>>3, so MIN_LEN=60 gives ew=8.
- DATA:
  - data_req=1 every cycle; word_cnt increments each cycle.
  - end_data_cnt=1 when word_cnt==dw-1.
  - On the last data word, last_mask = 8'hFF if len[2:0]==0, else (1<<len[2:0])-1. All other words show 8'hFF.
  - After the last word, go to PAD if ew>dw, else FCS.
- PAD:
  - in_pad=1; word_cnt continues incrementing; end_pad_cnt when word_cnt==ew-1.
  - last_mask=8'hFF on all pad words except the final one, which shows the MIN_LEN[2:0] mask (8'h0F for 60). Then go to FCS.
  - When pad is needed, the final data word's last_mask still reflects len, not MIN_LEN.
- FCS: one cycle, then IFG.
- IFG: IFG_WORDS cycles, then IDLE. start_tx is ignored in every state except IDLE, with no ack.
- Underrun: client_valid=0 while data_req=1 gives an underrun pulse. The FSM then goes directly to IFG (PAD/FCS skipped), and word_cnt is not advanced that cycle.
- Counters are LEN_W wide; the range check on frame_len guarantees no wrap.
- Reset mid-frame returns to IDLE immediately; no end strobes are emitted.

Optional Feature:
- Macro TX_PAD_EN.
- Defined: automatic padding as described above.
- Undefined:
  - ew is forced equal to dw and the PAD state is unreachable.
  - frame_len < MIN_LEN is rejected via len_err, like an over-length frame.

Decomposition:
- Shared package `tx_pkg`:
  - state encoding typedef.
  - WORD_BYTES=8, MIN_LEN, MAX_LEN defaults.
  - a function for the byte-count-to-mask conversion.
- One natural sub-module: `tx_word_counter`, a loadable LEN_W-bit up-counter with clear and enable, instantiated for word_cnt.

Test Plan:
- frame_len=64 with client_valid held high: PRE 1 cycle, DATA 8 cycles, end_data_cnt at word_cnt=7 with last_mask=FF, no PAD, FCS 1, IFG 2, then busy=0.
- frame_len=61: DATA 8 cycles; last word last_mask=8'h1F; no PAD.
- frame_len=20 with TX_PAD_EN:
  - DATA 3 cycles; last_mask=8'h0F on word 2.
  - PAD on words 3..7; end_pad_cnt at word 7 with mask 0F.
- frame_len=20 without TX_PAD_EN: len_err pulse; state stays IDLE.
- frame_len=0 or 1519: len_err pulse, no start_ack.
- frame_len=100 with client_valid dropped at word 5: one underrun pulse, then IFG for 2 cycles, then IDLE. start_tx asserted during IFG is ignored.
- Reset asserted during DATA: all outputs 0 asynchronously. After release, a new frame with len=64 completes normally.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the 10G MAC TX word sequencer: state encoding,
// default frame limits and the byte-count to valid-byte-mask helper.
package tx_pkg;

  localparam int WORD_BYTES    = 8;
  localparam int DEF_LEN_W     = 13;
  localparam int DEF_MAX_LEN   = 1518;
  localparam int DEF_MIN_LEN   = 60;
  localparam int DEF_IFG_WORDS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  // A remainder of zero means the word is completely full.
  function automatic logic [WORD_BYTES-1:0] bytes_to_mask(input logic [2:0] nbytes);
    logic [WORD_BYTES-1:0] m;
    if (nbytes == 3'd0) m = '1;
    else                m = (8'h01 << nbytes) - 8'h01;
    return m;
  endfunction

endpackage

// File: rtl/tx_word_counter.sv
// Loadable up-counter with synchronous clear and count enable; clear wins
// over load, load wins over enable.
module tx_word_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tx_num_sequencer.sv
// TX frame-phase sequencer: PRE -> DATA -> [PAD] -> FCS -> IFG per frame.
// Build with TX_PAD_EN defined to pad short frames up to MIN_LEN.
module tx_num_sequencer
  import tx_pkg::*;
#(
  parameter int LEN_W     = DEF_LEN_W,
  parameter int MAX_LEN   = DEF_MAX_LEN,
  parameter int MIN_LEN   = DEF_MIN_LEN,
  parameter int IFG_WORDS = DEF_IFG_WORDS
) (
  input  logic             txclk,
  input  logic             reset,
  input  logic             start_tx,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             client_valid,
  output logic             start_ack,
  output logic             len_err,
  output logic             in_pre,
  output logic             data_req,
  output logic             in_pad,
  output logic             in_fcs,
  output logic             in_ifg,
  output logic [LEN_W-1:0] word_cnt,
  output logic [7:0]       last_mask,
  output logic             end_data_cnt,
  output logic             end_pad_cnt,
  output logic             underrun,
  output logic             busy
);

  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] IFG_L   = LEN_W'(IFG_WORDS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] SEVEN   = LEN_W'(7);
  localparam logic [2:0]       MIN_REM = MIN_L[2:0];

  tx_state_e        state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [LEN_W-1:0] dw_q, dw_d, ew_q, ew_d, ifg_q, ifg_d;
  logic             ack_q, ack_d, err_q, err_d, und_q, und_d;
  logic             len_ok, cnt_clr, cnt_en;
  logic [LEN_W-1:0] pad_len;

`ifdef TX_PAD_EN
  assign len_ok  = (frame_len >= ONE) && (frame_len <= MAX_L);
  assign pad_len = (frame_len < MIN_L) ? MIN_L : frame_len;
`else
  assign len_ok  = (frame_len >= MIN_L) && (frame_len <= MAX_L);
  assign pad_len = frame_len;
`endif

  tx_word_counter #(.W(LEN_W)) u_word_cnt (
    .clk        (txclk),
    .rst_n      (reset),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .cnt_o      (word_cnt)
  );

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    dw_d         = dw_q;
    ew_d         = ew_q;
    ifg_d        = ifg_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    und_d        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    in_pre       = 1'b0;
    data_req     = 1'b0;
    in_pad       = 1'b0;
    in_fcs       = 1'b0;
    in_ifg       = 1'b0;
    end_data_cnt = 1'b0;
    end_pad_cnt  = 1'b0;
    last_mask    = 8'h00;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start_tx) begin
          if (len_ok) begin
            rem_d   = frame_len[2:0];
            dw_d    = (frame_len + SEVEN) >> 3;
            ew_d    = (pad_len + SEVEN) >> 3;
            ack_d   = 1'b1;
            state_d = ST_PRE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PRE: begin
        in_pre  = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        data_req     = 1'b1;
        end_data_cnt = (word_cnt == dw_q - ONE);
        last_mask    = end_data_cnt ? bytes_to_mask(rem_q) : 8'hFF;
        // A starved client aborts the frame: no pad, no FCS, straight to gap.
        if (!client_valid) begin
          und_d   = 1'b1;
          ifg_d   = '0;
          state_d = ST_IFG;
        end else begin
          cnt_en = 1'b1;
          if (end_data_cnt) state_d = (ew_q > dw_q) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        in_pad      = 1'b1;
        cnt_en      = 1'b1;
        end_pad_cnt = (word_cnt == ew_q - ONE);
        last_mask   = end_pad_cnt ? bytes_to_mask(MIN_REM) : 8'hFF;
        if (end_pad_cnt) state_d = ST_FCS;
      end
      ST_FCS: begin
        in_fcs  = 1'b1;
        ifg_d   = '0;
        state_d = ST_IFG;
      end
      ST_IFG: begin
        in_ifg = 1'b1;
        ifg_d  = ifg_q + ONE;
        if (ifg_q == IFG_L - ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dw_q    <= '0;
      ew_q    <= '0;
      ifg_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dw_q    <= dw_d;
      ew_q    <= ew_d;
      ifg_q   <= ifg_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      und_q   <= und_d;
    end
  end

  assign start_ack = ack_q;
  assign len_err   = err_q;
  assign underrun  = und_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
